carry_resolve_out: RTL and testbench

- Sequential successor to the encoder's final bitstream stage. Accepts up to LANES carry-tagged words per transfer, i.e. {carry part, byte}.
- Resolves carries across a held byte plus an arbitrarily long run of 0xFF bytes, and emits resolved bytes one per cycle over a valid/ready interface.
- Sits between the renormalisation stage and the byte packer/output FIFO. Supports an explicit end-of-frame flush.

---
 rtl/carry_resolve_out.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_carry_resolve_out.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_resolve_out.sv
// Carry resolver for the final bitstream stage: holds one byte plus a run of 0xFF bytes,
// folds incoming carries into them and emits resolved bytes one per cycle over valid/ready.
module carry_resolve_out #(
  parameter int unsigned OUTPUT_DATA_WIDTH = 8,
  parameter int unsigned INPUT_DATA_WIDTH  = 16,
  parameter int unsigned LANES             = 2,
  parameter int unsigned RUN_WIDTH         = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [$clog2(LANES+1)-1:0]          in_count,
  input  logic [LANES*INPUT_DATA_WIDTH-1:0]   in_bitstream,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]        out_bitstream,
  output logic                                out_last,
  output logic                                flush_done,
  output logic                                err_overflow,
  output logic                                pending_valid,
  output logic [RUN_WIDTH-1:0]                run_count
);

  localparam int unsigned B  = OUTPUT_DATA_WIDTH;
  localparam int unsigned IW = INPUT_DATA_WIDTH;
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LANE,
    EMIT,
    FLUSH_EMIT,
    FLUSH_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [LANES-1:0][IW-1:0] lanes_q, lanes_d;
  logic [CW-1:0]            lane_cnt_q, lane_cnt_d;
  logic [CW-1:0]            lane_idx_q, lane_idx_d;
  logic                     flush_pend_q, flush_pend_d;
  logic [B-1:0]             pend_q, pend_d;
  logic                     pv_q, pv_d;
  logic [RUN_WIDTH-1:0]     run_q, run_d;
  logic                     err_q, err_d;
  logic [RUN_WIDTH-1:0]     fill_cnt_q, fill_cnt_d;
  logic [B-1:0]             fill_val_q, fill_val_d;
  logic                     out_valid_q, out_valid_d;
  logic [B-1:0]             out_byte_q, out_byte_d;
  logic                     out_last_q, out_last_d;
  logic                     flush_done_q, flush_done_d;
  logic                     in_ready_q, in_ready_d;

  logic [IW-1:0]            word_c;
  logic                     carry_c;
  logic [B-1:0]             byte_c;
  logic                     byte_ff_c;
  logic                     carry_bad_c;
  logic                     head_v_c;
  logic [B-1:0]             head_c;
  logic [RUN_WIDTH-1:0]     fill_n_c;
  logic [B-1:0]             fill_v_c;
  logic                     route_c;
  logic                     start_flush_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lanes_q      <= '0;
      lane_cnt_q   <= '0;
      lane_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      pend_q       <= '0;
      pv_q         <= 1'b0;
      run_q        <= '0;
      err_q        <= 1'b0;
      fill_cnt_q   <= '0;
      fill_val_q   <= '0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= '0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lanes_q      <= lanes_d;
      lane_cnt_q   <= lane_cnt_d;
      lane_idx_q   <= lane_idx_d;
      flush_pend_q <= flush_pend_d;
      pend_q       <= pend_d;
      pv_q         <= pv_d;
      run_q        <= run_d;
      err_q        <= err_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_val_q   <= fill_val_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Next-state, carry resolution and output scheduling
  always_comb begin
    state_d       = state_q;
    lanes_d       = lanes_q;
    lane_cnt_d    = lane_cnt_q;
    lane_idx_d    = lane_idx_q;
    flush_pend_d  = flush_pend_q;
    pend_d        = pend_q;
    pv_d          = pv_q;
    run_d         = run_q;
    err_d         = err_q;
    fill_cnt_d    = fill_cnt_q;
    fill_val_d    = fill_val_q;
    out_valid_d   = out_valid_q;
    out_byte_d    = out_byte_q;
    out_last_d    = out_last_q;
    route_c       = 1'b0;
    start_flush_c = 1'b0;
    head_v_c      = 1'b0;
    head_c        = pend_q;
    fill_n_c      = '0;
    fill_v_c      = '1;

    word_c      = lanes_q[LW'(lane_idx_q)];
    carry_c     = |word_c[IW-1:B];
    byte_c      = word_c[B-1:0];
    byte_ff_c   = &byte_c;
    carry_bad_c = !pv_q || (&pend_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid && (in_count != '0)) begin
          lanes_d      = in_bitstream;
          lane_cnt_d   = (in_count > CW'(LANES)) ? CW'(LANES) : in_count;
          lane_idx_d   = '0;
          flush_pend_d = flush;
          state_d      = LANE;
        end else if (flush) begin
          start_flush_c = 1'b1;
        end
      end

      LANE: begin
        lane_idx_d = lane_idx_q + CW'(1);
        if (!carry_c) begin
          if (!byte_ff_c) begin
            head_v_c = pv_q;
            head_c   = pend_q;
            fill_n_c = run_q;
            fill_v_c = '1;
            pend_d   = byte_c;
            pv_d     = 1'b1;
            run_d    = '0;
          end else if (!pv_q) begin
            pend_d = '1;
            pv_d   = 1'b1;
          end else if (&run_q) begin
            err_d = 1'b1;
          end else begin
            run_d = run_q + RUN_WIDTH'(1);
          end
        end else begin
          // A carry into nothing or into 0xFF cannot be represented in the held byte
          if (carry_bad_c) err_d = 1'b1;
          head_c   = pend_q + B'(1);
          fill_v_c = '0;
          if (!byte_ff_c) begin
            head_v_c = !carry_bad_c;
            fill_n_c = run_q;
            pend_d   = byte_c;
            pv_d     = 1'b1;
            run_d    = '0;
          end else if (run_q == '0) begin
            pend_d = pend_q + B'(1);
            pv_d   = 1'b1;
            run_d  = RUN_WIDTH'(1);
          end else begin
            head_v_c = !carry_bad_c;
            fill_n_c = run_q - RUN_WIDTH'(1);
            pend_d   = '0;
            pv_d     = 1'b1;
            run_d    = RUN_WIDTH'(1);
          end
        end

        if (head_v_c || (fill_n_c != '0)) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          fill_val_d  = fill_v_c;
          if (head_v_c) begin
            out_byte_d = head_c;
            fill_cnt_d = fill_n_c;
          end else begin
            out_byte_d = fill_v_c;
            fill_cnt_d = fill_n_c - RUN_WIDTH'(1);
          end
        end else begin
          route_c = 1'b1;
        end
      end

      EMIT: begin
        if (out_ready) begin
          if (fill_cnt_q != '0) begin
            out_byte_d = fill_val_q;
            fill_cnt_d = fill_cnt_q - RUN_WIDTH'(1);
          end else begin
            out_valid_d = 1'b0;
            route_c     = 1'b1;
          end
        end
      end

      FLUSH_EMIT: begin
        if (out_ready) begin
          if (fill_cnt_q != '0) begin
            out_byte_d = '1;
            fill_cnt_d = fill_cnt_q - RUN_WIDTH'(1);
            out_last_d = (fill_cnt_q == RUN_WIDTH'(1));
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            pend_d      = '0;
            pv_d        = 1'b0;
            run_d       = '0;
            state_d     = FLUSH_DONE;
          end
        end
      end

      FLUSH_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // After a lane finishes (with or without emission): next lane, deferred flush, or idle
    if (route_c) begin
      if (lane_idx_d < lane_cnt_q) begin
        state_d = LANE;
      end else if (flush_pend_q) begin
        start_flush_c = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    if (start_flush_c) begin
      flush_pend_d = 1'b0;
      if (pv_d) begin
        state_d     = FLUSH_EMIT;
        out_valid_d = 1'b1;
        out_byte_d  = pend_d;
        fill_cnt_d  = run_d;
        fill_val_d  = '1;
        out_last_d  = (run_d == '0);
      end else begin
        state_d = FLUSH_DONE;
      end
    end

    in_ready_d   = (state_d == IDLE);
    flush_done_d = (state_d == FLUSH_DONE);
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_bitstream = out_byte_q;
  assign out_last      = out_last_q;
  assign flush_done    = flush_done_q;
  assign err_overflow  = err_q;
  assign pending_valid = pv_q;
  assign run_count     = run_q;

endmodule

// File: tb/tb_carry_resolve_out.sv
// Scoreboard bench for carry_resolve_out: directed words, expected bytes queued by the
// stimulus and consumed by an independent output monitor.
module tb_carry_resolve_out;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_count = 2'd0;
  logic [31:0] in_bitstream = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_bitstream;
  logic        out_last;
  logic        flush_done;
  logic        err_overflow;
  logic        pending_valid;
  logic [15:0] run_count;

  int          checks = 0;
  int          errors = 0;
  int          fd_count = 0;
  logic [8:0]  exp_q[$];
  logic        toggle_mode = 1'b0;
  logic        ready_lvl = 1'b1;

  carry_resolve_out dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_count      (in_count),
    .in_bitstream  (in_bitstream),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bitstream (out_bitstream),
    .out_last      (out_last),
    .flush_done    (flush_done),
    .err_overflow  (err_overflow),
    .pending_valid (pending_valid),
    .run_count     (run_count)
  );

  always #5 clk = ~clk;

  // Downstream ready: fixed level or toggling every cycle
  always @(posedge clk) begin
    #1;
    if (toggle_mode) out_ready = ~out_ready;
    else             out_ready = ready_lvl;
  end

  // Output monitor: every accepted byte must match the head of the expected queue
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset && out_valid && out_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_byte: got byte %02h last %0b, expected no output", out_bitstream, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_bitstream} !== e) begin
          errors = errors + 1;
          $display("FAIL out_byte: got byte %02h last %0b, expected byte %02h last %0b",
                   out_bitstream, out_last, e[7:0], e[8]);
        end
      end
    end
    if (flush_done) fd_count = fd_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic send(input logic [1:0] cnt, input logic [31:0] data, input logic fl);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_count = cnt; in_bitstream = data; flush = fl;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 500 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0; in_count = 2'd0; in_bitstream = 32'd0; flush = 1'b0;
  endtask

  task automatic send_flush();
    int t;
    t = 0;
    @(negedge clk);
    flush = 1'b1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL flush_timeout: in_ready stayed 0, expected 1 within 500 cycles");
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(in_ready && exp_q.size() == 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL idle_timeout: %0d bytes still expected, in_ready %0b", exp_q.size(), in_ready);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int fd0;
    int t;

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_pending", 32'(pending_valid), 32'd0);
    check("rst_run", 32'(run_count), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release_in_ready_high", 32'(in_ready), 32'd1);

    // 1: two bytes then flush
    expect_byte(8'h12, 1'b0);
    expect_byte(8'h34, 1'b1);
    send(2'd1, 32'h0000_0012, 1'b0);
    send(2'd1, 32'h0000_0034, 1'b0);
    fd0 = fd_count;
    send_flush();
    wait_idle();
    check("t1_flush_done_pulses", 32'(fd_count - fd0), 32'd1);
    check("t1_pending_cleared", 32'(pending_valid), 32'd0);

    // Zero-count transfer has no effect; empty flush pulses flush_done without bytes
    send(2'd0, 32'h0000_00AA, 1'b0);
    wait_idle();
    check("cnt0_no_pending", 32'(pending_valid), 32'd0);
    fd0 = fd_count;
    send_flush();
    wait_idle();
    check("empty_flush_done", 32'(fd_count - fd0), 32'd1);

    // 2: carry over a run of two 0xFF
    send(2'd1, 32'h0000_0040, 1'b0);
    send(2'd1, 32'h0000_00FF, 1'b0);
    send(2'd1, 32'h0000_00FF, 1'b0);
    wait_idle();
    check("t2_run2", 32'(run_count), 32'd2);
    check("t2_pending", 32'(pending_valid), 32'd1);
    expect_byte(8'h41, 1'b0);
    expect_byte(8'h00, 1'b0);
    expect_byte(8'h00, 1'b0);
    send(2'd1, 32'h0000_0105, 1'b0);
    wait_idle();
    check("t2_run0", 32'(run_count), 32'd0);
    check("t2_pending_held", 32'(pending_valid), 32'd1);
    expect_byte(8'h05, 1'b1);
    send_flush();
    wait_idle();

    // 3: carry over a single 0xFF, then carry into a trailing 0xFF
    expect_byte(8'h41, 1'b0);
    expect_byte(8'h00, 1'b0);
    send(2'd1, 32'h0000_0040, 1'b0);
    send(2'd1, 32'h0000_00FF, 1'b0);
    send(2'd1, 32'h0000_0107, 1'b0);
    wait_idle();
    check("t3a_run0", 32'(run_count), 32'd0);
    check("t3a_pending", 32'(pending_valid), 32'd1);
    expect_byte(8'h07, 1'b1);
    send_flush();
    wait_idle();
    send(2'd2, {16'h01FF, 16'h0040}, 1'b0);
    wait_idle();
    check("t3b_run1", 32'(run_count), 32'd1);
    check("t3b_pending", 32'(pending_valid), 32'd1);
    check("t3_no_err", 32'(err_overflow), 32'd0);
    pulse_reset();

    // 4: two lanes in one transfer with out_ready toggling
    toggle_mode = 1'b1;
    expect_byte(8'h11, 1'b0);
    send(2'd2, {16'h0022, 16'h0011}, 1'b0);
    check("t4_busy_lane0", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t4_busy_lane1", 32'(in_ready), 32'd0);
    wait_idle();
    expect_byte(8'h22, 1'b1);
    send_flush();
    wait_idle();
    toggle_mode = 1'b0;
    repeat (2) @(negedge clk);

    // 5: carry into a held 0xFF is sticky until reset
    pulse_reset();
    send(2'd1, 32'h0000_00FF, 1'b0);
    wait_idle();
    check("t5_err_before", 32'(err_overflow), 32'd0);
    send(2'd1, 32'h0000_0100, 1'b0);
    wait_idle();
    check("t5_err_set", 32'(err_overflow), 32'd1);
    expect_byte(8'h00, 1'b0);
    send(2'd1, 32'h0000_0033, 1'b0);
    wait_idle();
    check("t5_err_sticky", 32'(err_overflow), 32'd1);
    expect_byte(8'h33, 1'b1);
    send_flush();
    wait_idle();
    check("t5_err_after_flush", 32'(err_overflow), 32'd1);
    pulse_reset();
    check("t5_err_cleared", 32'(err_overflow), 32'd0);

    // 6: reset while three bytes are stalled in EMIT
    ready_lvl = 1'b0;
    repeat (2) @(negedge clk);
    send(2'd1, 32'h0000_0040, 1'b0);
    send(2'd1, 32'h0000_00FF, 1'b0);
    send(2'd1, 32'h0000_00FF, 1'b0);
    send(2'd1, 32'h0000_0105, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t6_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("t6_stall_byte", 32'(out_bitstream), 32'h41);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_pending", 32'(pending_valid), 32'd0);
    check("t6_rst_run", 32'(run_count), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_release_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t6_release_in_ready_high", 32'(in_ready), 32'd1);
    check("t6_no_output", 32'(out_valid), 32'd0);
    ready_lvl = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors = errors + 1;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
